// File: rtl/rsfq_gate_pkg.sv
// rsfq_gate_pkg: shared types and helpers for the RSFQ gate array.
//   chan_state_e       - per-channel gate state
//   MODE_INV/MODE_DRO  - output polarity selection
//   cnt_w()            - bits needed to hold 0..max_val
//   win_len()          - combined hold+setup window length
package rsfq_gate_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ARMED = 2'd1,
        ST_SET   = 2'd2,
        ST_UNK   = 2'd3
    } chan_state_e;

    localparam int MODE_INV = 0;
    localparam int MODE_DRO = 1;

    // Bits needed to represent every value 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

    function automatic int win_len(input int t_hold, input int t_setup);
        return t_hold + t_setup;
    endfunction

endpackage

// File: rtl/rsfq_gate_chan.sv
// rsfq_gate_chan: one clocked gate channel.
//   clk, rst_n   - system clock, asynchronous active-low reset
//   d_i          - data pulse for this channel
//   gclk_i       - shared gate-clock pulse
//   since_ok_i   - high when the cycles since the last gate clock,
//                  counting the current edge, reach the window length
//   out_o        - delayed output pulse
//   out_x_o      - high alongside out_o when the emitted value is unknown
//   viol_o       - one-cycle violation strobe
module rsfq_gate_chan
    import rsfq_gate_pkg::*;
#(
    parameter int MODE    = MODE_INV,
    parameter int WIN     = 3,
    parameter int DELAY   = 3,
    parameter int PULSE_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    input  logic gclk_i,
    input  logic since_ok_i,
    output logic out_o,
    output logic out_x_o,
    output logic viol_o
);

    localparam int TMR_W = cnt_w(WIN);
    localparam int PW_W  = cnt_w(PULSE_W);

    chan_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             viol_q, viol_d;
    logic             expire;
    logic             samp_val, samp_x, samp_bit;

    // Delay pipeline: valid flag, emitted bit and unknown flag per stage.
    logic [DELAY-1:0] pv_q, pv_d;
    logic [DELAY-1:0] pbit_q, pbit_d;
    logic [DELAY-1:0] px_q, px_d;

    logic             out_bit_q, out_x_q;
    logic [PW_W-1:0]  wcnt_q;

    // Timer value 1 means the window closes on this edge.
    assign expire = (tmr_q == TMR_W'(1));

    // Value sampled by a gate clock from the pre-update state. Unknown
    // always emits 1 regardless of polarity.
    always_comb begin
        samp_x   = (state_q == ST_UNK);
        samp_val = (state_q == ST_SET) || samp_x;
        if (samp_x) begin
            samp_bit = 1'b1;
        end else if (MODE == MODE_DRO) begin
            samp_bit = samp_val;
        end else begin
            samp_bit = ~samp_val;
        end
    end

    // Next state: expiry beats the gate-clock clear; a data pulse is
    // applied last so it arms a freshly cleared channel.
    always_comb begin
        state_d = state_q;
        viol_d  = 1'b0;
        tmr_d   = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
        if (expire) begin
            if (gclk_i || !since_ok_i) begin
                state_d = ST_UNK;
                viol_d  = 1'b1;
            end else begin
                state_d = ST_SET;
            end
        end else if (gclk_i) begin
            state_d = ST_EMPTY;
        end
        if (d_i) begin
            if (state_d == ST_EMPTY) begin
                state_d = ST_ARMED;
            end
            tmr_d = TMR_W'(WIN);
        end
    end

    assign pv_d[0]   = gclk_i;
    assign pbit_d[0] = samp_bit;
    assign px_d[0]   = samp_x;

    for (genvar gi = 1; gi < DELAY; gi++) begin : g_stage
        assign pv_d[gi]   = pv_q[gi-1];
        assign pbit_d[gi] = pbit_q[gi-1];
        assign px_d[gi]   = px_q[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            tmr_q     <= '0;
            viol_q    <= 1'b0;
            pv_q      <= '0;
            pbit_q    <= '0;
            px_q      <= '0;
            out_bit_q <= 1'b0;
            out_x_q   <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            viol_q  <= viol_d;
            pv_q    <= pv_d;
            pbit_q  <= pbit_d;
            px_q    <= px_d;
            // A new pulse replaces the active one and restarts its width.
            if (pv_q[DELAY-1]) begin
                out_bit_q <= pbit_q[DELAY-1];
                out_x_q   <= px_q[DELAY-1];
                wcnt_q    <= PW_W'(PULSE_W);
            end else if (wcnt_q != '0) begin
                wcnt_q <= wcnt_q - PW_W'(1);
            end
        end
    end

    assign out_o   = out_bit_q & (wcnt_q != '0);
    assign out_x_o = out_x_q & (wcnt_q != '0);
    assign viol_o  = viol_q;

endmodule

// File: rtl/rsfq_gate_array.sv
// rsfq_gate_array: CHANNELS clocked RSFQ-style gates sharing one gate clock.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   d_pulse     - per-channel data pulses
//   gclk_pulse  - shared gate-clock pulse
//   vcnt_clr    - synchronous clear of viol_cnt
//   out, out_x  - per-channel delayed output pulse and unknown flag
//   viol        - per-channel violation strobe
//   viol_cnt    - saturating total of violations
module rsfq_gate_array
    import rsfq_gate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_INV,
    parameter int T_HOLD   = 1,
    parameter int T_SETUP  = 2,
    parameter int DELAY    = 3,
    parameter int PULSE_W  = 2,
    parameter int VCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] d_pulse,
    input  logic                gclk_pulse,
    input  logic                vcnt_clr,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_x,
    output logic [CHANNELS-1:0] viol,
    output logic [VCNT_W-1:0]   viol_cnt
);

    localparam int WIN   = win_len(T_HOLD, T_SETUP);
    localparam int SC_W  = cnt_w(WIN);
    localparam int SUM_W = cnt_w(CHANNELS);

    logic [SC_W-1:0]   since_q, since_d;
    logic              since_ok;
    logic [SUM_W-1:0]  viol_sum;
    logic [VCNT_W:0]   cnt_sum;
    logic [VCNT_W-1:0] viol_cnt_q, viol_cnt_d;

    // since_q counts cycles completed after the last gate clock; the check
    // at an expiry edge also counts the cycle ending on that edge.
    assign since_ok = (since_q >= SC_W'(WIN - 1));

    always_comb begin
        since_d = since_q;
        if (gclk_pulse) begin
            since_d = '0;
        end else if (since_q != SC_W'(WIN)) begin
            since_d = since_q + SC_W'(1);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        rsfq_gate_chan #(
            .MODE    (MODE),
            .WIN     (WIN),
            .DELAY   (DELAY),
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .d_i        (d_pulse[gi]),
            .gclk_i     (gclk_pulse),
            .since_ok_i (since_ok),
            .out_o      (out[gi]),
            .out_x_o    (out_x[gi]),
            .viol_o     (viol[gi])
        );
    end

    // Counts the strobes visible during the cycle ending at this edge.
    always_comb begin
        viol_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            viol_sum = viol_sum + SUM_W'(viol[i]);
        end
    end

    assign cnt_sum = {1'b0, viol_cnt_q} + (VCNT_W+1)'(viol_sum);

    always_comb begin
        if (vcnt_clr) begin
            viol_cnt_d = '0;
        end else if (cnt_sum[VCNT_W]) begin
            viol_cnt_d = '1;
        end else begin
            viol_cnt_d = cnt_sum[VCNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_q    <= SC_W'(WIN);
            viol_cnt_q <= '0;
        end else begin
            since_q    <= since_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_cnt = viol_cnt_q;

endmodule

// File: doc/rsfq_gate_array.md
RSFQ_GATE_ARRAY -- requirements
Module: rsfq_gate_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent clocked gate channels.
REQ-002 Parameter MODE, default 0: 0 = INV (out = ~state), 1 = DRO (out = state).
REQ-003 Parameter T_HOLD, default 1: hold window in clk cycles, range 0..15.
REQ-004 Parameter T_SETUP, default 2: setup window in clk cycles, range 1..15.
REQ-005 Parameter DELAY, default 3: clk cycles from gate-clock pulse to output assertion, range 1..31.
REQ-006 Parameter PULSE_W, default 2: output pulse length in clk cycles, range 1..15.
REQ-007 Parameter VCNT_W, default 16: violation counter width.
REQ-008 clk  input  1  system clock; all logic on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 d_pulse  input  CHANNELS  per-channel data pulse; each cycle high is one SFQ event.
REQ-011 gclk_pulse  input  1  shared gate-clock pulse; each cycle high is one clock event.
REQ-012 vcnt_clr  input  1  synchronous clear of viol_cnt.
REQ-013 out  output  CHANNELS  per-channel output pulse.
REQ-014 out_x  output  CHANNELS  high alongside out when the emitted value is indeterminate.
REQ-015 viol  output  CHANNELS  one-cycle strobe on a hold/setup violation.
REQ-016 viol_cnt  output  VCNT_W  saturating count of all violations across channels.

Function
REQ-017 Each channel SHALL hold state EMPTY, ARMED, SET or UNK; reset state is EMPTY.
REQ-018 A d_pulse SHALL load the channel window timer with WIN = T_HOLD+T_SETUP and enter ARMED from EMPTY; in any other state, the state is unchanged and only the timer reloads.
REQ-019 Timer expiry SHALL check since_clk, a saturating count of cycles since the last gclk_pulse: since_clk >= WIN sets SET; otherwise UNK, with one viol strobe for that channel.
REQ-020 gclk_pulse SHALL sample every channel's pre-update state: SET gives value 1; EMPTY or ARMED give 0; UNK gives value 1 with out_x.
REQ-021 The emitted bit SHALL be the sampled value in DRO mode and its inverse in INV mode; out_x is not inverted, and in INV mode UNK still emits out = 1 with out_x = 1.
REQ-022 gclk_pulse SHALL clear the channel state to EMPTY and reset since_clk to 0; a running window timer keeps counting.
REQ-023 Timer expiry in the same cycle as gclk_pulse SHALL take precedence over the clear: the state becomes UNK, with a viol strobe.
REQ-024 d_pulse in the same cycle as gclk_pulse SHALL arm the channel after the clear.
REQ-025 gclk_pulse at edge k SHALL assert out and out_x from edge k+DELAY for exactly PULSE_W cycles.
REQ-026 gclk_pulse events DELAY cycles or less apart SHALL be pipelined and not lost.
REQ-027 If a new output pulse begins while one is active, the new value SHALL replace the old one and the width count SHALL restart.
REQ-028 viol_cnt SHALL add the number of viol bits high in a cycle, saturate at all-ones, and read 0 after any vcnt_clr; vcnt_clr takes precedence over a same-cycle increment.
REQ-029 since_clk SHALL saturate at WIN; on exit from reset it starts saturated.

Reset
REQ-030 rst_n low SHALL asynchronously force out, out_x, viol = 0, viol_cnt = 0, all states to EMPTY, all timers idle and the delay pipeline to empty.
REQ-031 Pulses captured before reset deassertion SHALL never appear at out.
REQ-032 The first clk edge after rst_n rises SHALL accept d_pulse and gclk_pulse normally.

Structure
REQ-033 Package rsfq_gate_pkg SHALL hold the channel-state enum, MODE constants and helper functions for timer widths.
REQ-034 One sub-module, rsfq_gate_chan, SHALL implement one channel's state, timer, delay pipeline and width counter, instantiated CHANNELS times.
REQ-035 The top level SHALL hold since_clk, the viol adder and viol_cnt.

Verification (defaults: WIN = 3)
REQ-036 Reset, then gclk_pulse at edge 10 with no data -> out = 4'b1111, out_x = 0, during edges 13-14 only.
REQ-037 d_pulse[0] at edge 20, gclk at edge 30 -> out[0] = 0 at edges 33-34, out[3:1] = 1, viol = 0.
REQ-038 gclk at 40, d_pulse[1] at 41 -> expiry at 44 with since_clk = 4: no violation.
REQ-039 gclk at 50, d_pulse[1] at 50, gclk at 52 -> out[1] = 1, out_x[1] = 0 at edges 55-56.
REQ-040 Same d_pulse[1] at 50, expiry at 53, next gclk at 60 -> out[1] = 1, out_x[1] = 1 at 63-64.
REQ-041 gclk at 50, d_pulse[2] at 51, gclk at 54 (expiry coincides) -> viol[2] = 1 at 54, state UNK.
REQ-042 Same case, next gclk at 60 -> out[2] = 1, out_x[2] = 1 at 63-64.
REQ-043 All-channel violation with viol_cnt preset to 16'hFFFE -> reads 16'hFFFF, holds there, then 0 after vcnt_clr.
REQ-044 gclk at 70 and 71 with PULSE_W = 2 -> out contiguous at edges 73-75, no lost event.
REQ-045 rst_n low at edge 72 during that run -> out, out_x = 0 immediately; nothing emitted at edges 73-75.
